// File: rtl/blit_pkg.sv
// Definitions shared by the blitter bus slice: 68k function codes and adapter state encoding.
package blit_pkg;

    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TERM = 2'd2
    } adp_state_t;

endpackage

// File: rtl/m68k_bus_adapter.sv
// Bridges 68000 strobe cycles to a one-cycle cpu_req/cpu_ack handshake; IACK is autovectored locally.
// Latency: strobe to cpu_req 1 cycle; cpu_ack to DTACK/BERR 1 cycle; strobe negation to release 1 cycle.
// Backpressure: the CPU is stalled by withholding DTACK; a watchdog forces BERR after TIMEOUT cycles.
module m68k_bus_adapter
    import blit_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m68k_as_n,
    input  logic        m68k_uds_n,
    input  logic        m68k_lds_n,
    input  logic        m68k_rw,
    input  logic [2:0]  m68k_fc,
    input  logic [22:0] m68k_addr,
    input  logic [15:0] m68k_dout,
    output logic [15:0] m68k_din,
    output logic        m68k_dtack_n,
    output logic        m68k_berr_n,
    output logic        m68k_vpa_n,
    output logic        cpu_req,
    output logic [23:0] cpu_addr,
    output logic [15:0] cpu_wdata,
    output logic [1:0]  cpu_wstrb,
    output logic        cpu_we,
    input  logic        cpu_ack,
    input  logic [15:0] cpu_rdata,
    input  logic        cpu_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);

    adp_state_t     state, state_nxt;
    logic [WDW-1:0] wd, wd_nxt, wd_inc;
    logic           armed, armed_nxt;
    logic           dtack_n_nxt, berr_n_nxt, vpa_n_nxt, req_nxt;
    logic [15:0]    din_nxt, wdata_nxt;
    logic [23:0]    addr_nxt;
    logic [1:0]     wstrb_nxt;
    logic           we_nxt;
    logic           strobe_any, strobes_idle;

    assign strobe_any   = ~m68k_uds_n | ~m68k_lds_n;
    assign strobes_idle = m68k_uds_n & m68k_lds_n;
    assign wd_inc       = wd + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wd           <= '0;
            armed        <= 1'b0;
            m68k_dtack_n <= 1'b1;
            m68k_berr_n  <= 1'b1;
            m68k_vpa_n   <= 1'b1;
            m68k_din     <= '0;
            cpu_req      <= 1'b0;
            cpu_addr     <= '0;
            cpu_wdata    <= '0;
            cpu_wstrb    <= '0;
            cpu_we       <= 1'b0;
        end else begin
            state        <= state_nxt;
            wd           <= wd_nxt;
            armed        <= armed_nxt;
            m68k_dtack_n <= dtack_n_nxt;
            m68k_berr_n  <= berr_n_nxt;
            m68k_vpa_n   <= vpa_n_nxt;
            m68k_din     <= din_nxt;
            cpu_req      <= req_nxt;
            cpu_addr     <= addr_nxt;
            cpu_wdata    <= wdata_nxt;
            cpu_wstrb    <= wstrb_nxt;
            cpu_we       <= we_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wd_nxt      = wd;
        armed_nxt   = armed | strobes_idle;
        dtack_n_nxt = m68k_dtack_n;
        berr_n_nxt  = m68k_berr_n;
        vpa_n_nxt   = m68k_vpa_n;
        din_nxt     = m68k_din;
        req_nxt     = 1'b0;
        addr_nxt    = cpu_addr;
        wdata_nxt   = cpu_wdata;
        wstrb_nxt   = cpu_wstrb;
        we_nxt      = cpu_we;

        case (state)
            IDLE: begin
                if (!m68k_as_n && strobe_any && armed) begin
                    if (m68k_fc == FC_CPU_SPACE) begin
                        vpa_n_nxt = 1'b0;
                        state_nxt = TERM;
                    end else begin
                        addr_nxt  = {m68k_addr, 1'b0};
                        wstrb_nxt = {~m68k_uds_n, ~m68k_lds_n};
                        we_nxt    = ~m68k_rw;
                        wdata_nxt = m68k_dout;
                        req_nxt   = 1'b1;
                        wd_nxt    = '0;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                wd_nxt = wd_inc;
                // ack is checked first so it beats a timeout landing on the same edge
                if (cpu_ack) begin
                    if (cpu_err) begin
                        berr_n_nxt = 1'b0;
                    end else begin
                        dtack_n_nxt = 1'b0;
                        if (!cpu_we) din_nxt = cpu_rdata;
                    end
                    state_nxt = TERM;
                end else if (wd_inc == WD_LIMIT) begin
                    berr_n_nxt = 1'b0;
                    state_nxt  = TERM;
                end
            end
            TERM: begin
                // clearing armed forces a full strobe-high cycle before the next request
                if (strobes_idle) begin
                    dtack_n_nxt = 1'b1;
                    berr_n_nxt  = 1'b1;
                    vpa_n_nxt   = 1'b1;
                    armed_nxt   = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_m68k_bus_adapter.sv
// Directed bench for m68k_bus_adapter: vector table of single accesses plus timeout, TAS and reset sequences.
module tb_m68k_bus_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m68k_as_n, m68k_uds_n, m68k_lds_n, m68k_rw;
    logic [2:0]  m68k_fc;
    logic [22:0] m68k_addr;
    logic [15:0] m68k_dout, m68k_din;
    logic        m68k_dtack_n, m68k_berr_n, m68k_vpa_n;
    logic        cpu_req, cpu_we, cpu_ack, cpu_err;
    logic [23:0] cpu_addr;
    logic [15:0] cpu_wdata, cpu_rdata;
    logic [1:0]  cpu_wstrb;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    int mutex_bad = 0;

    always #5 clk = ~clk;

    m68k_bus_adapter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m68k_as_n(m68k_as_n), .m68k_uds_n(m68k_uds_n), .m68k_lds_n(m68k_lds_n),
        .m68k_rw(m68k_rw), .m68k_fc(m68k_fc), .m68k_addr(m68k_addr),
        .m68k_dout(m68k_dout), .m68k_din(m68k_din),
        .m68k_dtack_n(m68k_dtack_n), .m68k_berr_n(m68k_berr_n), .m68k_vpa_n(m68k_vpa_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_we(cpu_we),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err)
    );

    always @(negedge clk) begin
        if (cpu_req) req_cnt++;
        if (!rst && $countones({~m68k_dtack_n, ~m68k_berr_n, ~m68k_vpa_n}) > 1) mutex_bad++;
    end

    typedef struct {
        string       name;
        logic [2:0]  fc;
        logic [22:0] addr;
        logic        uds_n, lds_n, rw;
        logic [15:0] dout;
        int          dly;
        logic [15:0] rdata;
        logic        err;
        logic        exp_req;
        logic [23:0] exp_addr;
        logic [1:0]  exp_wstrb;
        logic        exp_we;
        logic [15:0] exp_wdata;
        logic [2:0]  exp_term;   // {dtack_n, berr_n, vpa_n} while terminating
        logic [15:0] exp_din;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(string name, logic [2:0] fc, logic [22:0] addr,
                                logic uds_n, logic lds_n, logic rw, logic [15:0] dout,
                                int dly, logic [15:0] rdata, logic err, logic exp_req,
                                logic [23:0] exp_addr, logic [1:0] exp_wstrb, logic exp_we,
                                logic [15:0] exp_wdata, logic [2:0] exp_term, logic [15:0] exp_din);
        vec_t v;
        v.name = name; v.fc = fc; v.addr = addr; v.uds_n = uds_n; v.lds_n = lds_n;
        v.rw = rw; v.dout = dout; v.dly = dly; v.rdata = rdata; v.err = err;
        v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_wstrb = exp_wstrb;
        v.exp_we = exp_we; v.exp_wdata = exp_wdata; v.exp_term = exp_term; v.exp_din = exp_din;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        m68k_as_n = 1'b1; m68k_uds_n = 1'b1; m68k_lds_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int base;
        base = req_cnt;
        m68k_fc = v.fc; m68k_addr = v.addr; m68k_rw = v.rw; m68k_dout = v.dout;
        m68k_as_n = 1'b0; m68k_uds_n = v.uds_n; m68k_lds_n = v.lds_n;
        cyc();
        chk({v.name, "_req"},   cpu_req,   v.exp_req);
        chk({v.name, "_addr"},  cpu_addr,  v.exp_addr);
        chk({v.name, "_wstrb"}, cpu_wstrb, v.exp_wstrb);
        chk({v.name, "_we"},    cpu_we,    v.exp_we);
        chk({v.name, "_wdata"}, cpu_wdata, v.exp_wdata);
        if (v.exp_req) begin
            repeat (v.dly) cyc();
            cpu_ack = 1'b1; cpu_rdata = v.rdata; cpu_err = v.err;
            cyc();
            cpu_ack = 1'b0; cpu_err = 1'b0; cpu_rdata = 16'h0;
        end else begin
            cyc();
        end
        chk({v.name, "_term"}, {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, v.exp_term);
        chk({v.name, "_din"},  m68k_din, v.exp_din);
        cyc();
        chk({v.name, "_hold"}, {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, v.exp_term);
        bus_idle();
        cyc();
        chk({v.name, "_release"}, {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, 3'b111);
        cyc();
        cyc();
        chk({v.name, "_nreq"}, req_cnt - base, {31'd0, v.exp_req});
    endtask

    initial begin
        int base;
        int berr_at;
        rst = 1'b1;
        bus_idle();
        m68k_rw = 1'b1; m68k_fc = 3'd6; m68k_addr = '0; m68k_dout = '0;
        cpu_ack = 1'b0; cpu_err = 1'b0; cpu_rdata = '0;

        vecs[0] = mk("word_read",  3'd6, 23'h020008, 1'b0, 1'b0, 1'b1, 16'h0000, 3, 16'hBEEF, 1'b0,
                     1'b1, 24'h040010, 2'b11, 1'b0, 16'h0000, 3'b011, 16'hBEEF);
        vecs[1] = mk("lo_write",   3'd5, 23'h000080, 1'b1, 1'b0, 1'b0, 16'h1234, 1, 16'h5555, 1'b0,
                     1'b1, 24'h000100, 2'b01, 1'b1, 16'h1234, 3'b011, 16'hBEEF);
        vecs[2] = mk("dec_err",    3'd6, 23'h000002, 1'b0, 1'b0, 1'b1, 16'hA5A5, 0, 16'hDEAD, 1'b1,
                     1'b1, 24'h000004, 2'b11, 1'b0, 16'hA5A5, 3'b101, 16'hBEEF);
        vecs[3] = mk("iack",       3'd7, 23'h7FFFF8, 1'b1, 1'b0, 1'b1, 16'hFFFF, 0, 16'h0000, 1'b0,
                     1'b0, 24'h000004, 2'b11, 1'b0, 16'hA5A5, 3'b110, 16'hBEEF);
        vecs[4] = mk("hi_read",    3'd5, 23'h7FFFFF, 1'b0, 1'b1, 1'b1, 16'h0F0F, 5, 16'h00C3, 1'b0,
                     1'b1, 24'hFFFFFE, 2'b10, 1'b0, 16'h0F0F, 3'b011, 16'h00C3);

        cyc(); cyc();
        chk("rst_term",  {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, 3'b111);
        chk("rst_req",   cpu_req, 1'b0);
        chk("rst_addr",  cpu_addr, 24'h0);
        chk("rst_wdata", cpu_wdata, 16'h0);
        chk("rst_wstrb", cpu_wstrb, 2'b00);
        chk("rst_we",    cpu_we, 1'b0);
        chk("rst_din",   m68k_din, 16'h0);
        rst = 1'b0;
        cyc(); cyc();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Watchdog: no ack, BERR must appear exactly 16 cycles into WAIT; a late ack is swallowed.
        base = req_cnt;
        m68k_fc = 3'd6; m68k_addr = 23'h000100; m68k_rw = 1'b1;
        m68k_as_n = 1'b0; m68k_uds_n = 1'b0; m68k_lds_n = 1'b0;
        cyc();
        chk("to_req", cpu_req, 1'b1);
        berr_at = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (berr_at == 0 && !m68k_berr_n) berr_at = k;
        end
        chk("to_cycle", berr_at, 16);
        repeat (1) cyc();
        cpu_ack = 1'b1; cpu_rdata = 16'h1111;
        cyc();
        cpu_ack = 1'b0;
        cyc();
        chk("to_late_ack", {m68k_dtack_n, m68k_berr_n}, 2'b10);
        chk("to_late_din", m68k_din, 16'h00C3);
        bus_idle();
        cyc();
        chk("to_release", m68k_berr_n, 1'b1);
        cpu_ack = 1'b1;
        cyc();
        cpu_ack = 1'b0;
        cyc();
        chk("to_idle_ack", {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, 3'b111);
        chk("to_nreq", req_cnt - base, 1);

        // Ack sampled on the same edge as the timeout: ack wins.
        m68k_as_n = 1'b0; m68k_uds_n = 1'b0; m68k_lds_n = 1'b0;
        cyc();
        repeat (15) cyc();
        cpu_ack = 1'b1; cpu_rdata = 16'h7E57;
        cyc();
        cpu_ack = 1'b0;
        chk("race_term", {m68k_dtack_n, m68k_berr_n}, 2'b01);
        chk("race_din",  m68k_din, 16'h7E57);
        bus_idle();
        cyc(); cyc(); cyc();

        // TAS: AS held low, strobes cycle between the read and write halves.
        base = req_cnt;
        m68k_addr = 23'h001000; m68k_rw = 1'b1; m68k_dout = 16'h0000;
        m68k_as_n = 1'b0; m68k_lds_n = 1'b0;
        cyc();
        chk("tas_rd_req", {cpu_req, cpu_we, cpu_wstrb}, 4'b1001);
        chk("tas_rd_addr", cpu_addr, 24'h002000);
        cpu_ack = 1'b1; cpu_rdata = 16'h0012;
        cyc();
        cpu_ack = 1'b0;
        chk("tas_rd_dtack", m68k_dtack_n, 1'b0);
        m68k_lds_n = 1'b1;
        cyc();
        chk("tas_mid_release", m68k_dtack_n, 1'b1);
        cyc();
        m68k_rw = 1'b0; m68k_dout = 16'h0092; m68k_lds_n = 1'b0;
        cyc();
        chk("tas_wr_req", {cpu_req, cpu_we, cpu_wstrb}, 4'b1101);
        chk("tas_wr_data", cpu_wdata, 16'h0092);
        cyc();
        cpu_ack = 1'b1;
        cyc();
        cpu_ack = 1'b0;
        chk("tas_wr_dtack", m68k_dtack_n, 1'b0);
        chk("tas_wr_din", m68k_din, 16'h0012);
        bus_idle();
        cyc(); cyc(); cyc();
        chk("tas_nreq", req_cnt - base, 2);

        // Reset in WAIT: everything returns to reset values and the late ack is ignored.
        base = req_cnt;
        m68k_rw = 1'b0; m68k_addr = 23'h0ABCDE; m68k_dout = 16'hCAFE;
        m68k_as_n = 1'b0; m68k_uds_n = 1'b0; m68k_lds_n = 1'b0;
        cyc();
        chk("rw_req", cpu_req, 1'b1);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus_idle();
        chk("rw_term",  {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, 3'b111);
        chk("rw_bus",   {cpu_req, cpu_we, cpu_wstrb}, 4'b0000);
        chk("rw_addr",  cpu_addr, 24'h0);
        chk("rw_wdata", cpu_wdata, 16'h0);
        chk("rw_din",   m68k_din, 16'h0);
        cpu_ack = 1'b1; cpu_rdata = 16'h9999;
        cyc();
        cpu_ack = 1'b0;
        cyc();
        chk("rw_ack_ignored", {m68k_dtack_n, m68k_berr_n, m68k_vpa_n}, 3'b111);
        chk("rw_ack_din", m68k_din, 16'h0);
        chk("rw_nreq", req_cnt - base, 1);

        chk("mutex", mutex_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_adapter.md
Name: m68k_bus_adapter

Overview:
Upstream stage of the CPU bus decoder. It converts the 68000 core's strobe-based bus (AS/UDS/LDS/RW/FC, DTACK/BERR/VPA) into the single-cycle `cpu_req`/`cpu_ack` handshake that the bus decoder consumes. It also terminates interrupt-acknowledge cycles locally with autovectoring, and bounds every access with a watchdog that raises bus error.

Parameters:
- TIMEOUT, 255: maximum number of cycles spent in WAIT before forcing a bus error; must be ≥ 1.

Ports:
- clk  in  1  system clock; single clock domain; the 68k core runs off the same clock.
- rst  in  1  synchronous reset, active-high.
- m68k_as_n  in  1  address strobe, active-low.
- m68k_uds_n  in  1  upper data strobe (D15:8), active-low.
- m68k_lds_n  in  1  lower data strobe (D7:0), active-low.
- m68k_rw  in  1  1 = read, 0 = write.
- m68k_fc  in  3  function code; 3'b111 = CPU space (interrupt acknowledge).
- m68k_addr  in  23  word address A23:A1.
- m68k_dout  in  16  CPU write data.
- m68k_din  out  16  read data returned to the CPU.
- m68k_dtack_n  out  1  data acknowledge, active-low.
- m68k_berr_n  out  1  bus error, active-low.
- m68k_vpa_n  out  1  valid peripheral address (autovector), active-low.
- cpu_req  out  1  one-cycle request pulse to the bus decoder.
- cpu_addr  out  24  byte address, {m68k_addr, 1'b0}.
- cpu_wdata  out  16  write data.
- cpu_wstrb  out  2  {upper, lower} byte enables.
- cpu_we  out  1  1 = write.
- cpu_ack  in  1  decoder completion pulse.
- cpu_rdata  in  16  decoder read data; valid with `cpu_ack`.
- cpu_err  in  1  decoder error flag; qualified by `cpu_ack`.

Behaviour:
- **Reset:**
  - `m68k_dtack_n`, `m68k_berr_n` and `m68k_vpa_n` = 1.
  - `cpu_req` = 0, `cpu_we` = 0, `cpu_wstrb` = 0, `cpu_addr` = 0, `cpu_wdata` = 0, `m68k_din` = 0.
  - State = IDLE, watchdog = 0.
  - Reset mid-access abandons the access; an `cpu_ack` arriving after reset is ignored.
- **States:** IDLE, WAIT, TERM.
- **IDLE:**
  - Acts when `as_n`=0 AND (`uds_n`=0 OR `lds_n`=0) AND `armed`=1.
  - If `fc` = 7 (interrupt acknowledge): `vpa_n` <= 0, go to TERM. No `cpu_req` is issued.
  - Otherwise, registered on that edge:
    - `cpu_addr` <= {addr, 0}
    - `cpu_wstrb` <= {~uds_n, ~lds_n}
    - `cpu_we` <= ~rw
    - `cpu_wdata` <= dout
    - `cpu_req` <= 1 for exactly one cycle
    - clear the watchdog and go to WAIT.
  - Write cycles: the CPU asserts the data strobes after AS, so gating on the strobes makes `cpu_wdata` valid. Latency from strobe to `cpu_req` = 1 cycle.
- **WAIT:**
  - The watchdog increments every cycle.
  - `cpu_ack`=1 with `cpu_err`=0: `m68k_din` <= `cpu_rdata` (reads only; held on writes), `dtack_n` <= 0, go to TERM.
  - `cpu_ack`=1 with `cpu_err`=1: `berr_n` <= 0, `din` unchanged, go to TERM.
  - Watchdog reaches TIMEOUT without `cpu_ack`: `berr_n` <= 0, go to TERM.
  - If `cpu_ack` and the timeout occur in the same cycle, `cpu_ack` wins.
  - The `cpu_ack` of a timed-out access must be swallowed: stay deaf to it in TERM/IDLE.
  - The decoder's own error path does not exist here; only `cpu_err` and the watchdog raise BERR.
- **TERM:**
  - Hold the asserted `dtack_n`/`berr_n`/`vpa_n` until `uds_n` = `lds_n` = 1 (covers AS negation).
  - Then release all three to 1 in the next cycle, clear `armed`, and go to IDLE.
- **Re-arm rule:** `armed` is set while both strobes are high.
  - Guarantees exactly one `cpu_req` per strobe assertion.
  - Supports TAS read-modify-write: AS stays low while the strobes cycle, which produces a second request for the write half.
- **Hold requirement:** `cpu_addr`, `cpu_wdata`, `cpu_wstrb` and `cpu_we` stay stable from the `cpu_req` pulse until the next request.
- **Mutual exclusion:** at most one of `dtack_n`, `berr_n`, `vpa_n` is low at any time.

Decomposition:
- Shared package `blit_pkg`:
  - `FC_CPU_SPACE` = 3'b111
  - adapter state encoding: IDLE=0, WAIT=1, TERM=2
- No sub-module. The watchdog is an inline counter of width $clog2(TIMEOUT+1).

Test Plan:
- **Word read.** Stimulus: `fc`=6, `addr` 0x020008 (byte 0x040010), both strobes low, `rw`=1; decoder acks after 3 cycles with `rdata`=0xBEEF. Required: `cpu_req` pulse one cycle after the strobes with `addr`=0x040010, `we`=0, `wstrb`=2'b11; `din`=0xBEEF and `dtack_n`=0 the cycle after `cpu_ack`; `dtack_n`=1 one cycle after the strobes negate.
- **Lower-byte write.** Stimulus: `addr` byte 0x000100, `lds` only, `rw`=0, `dout`=0x1234. Required: `wstrb`=2'b01, `we`=1, `wdata`=0x1234; DTACK on ack; `din` unchanged.
- **Decoder error.** Stimulus: `cpu_ack`=`cpu_err`=1 at address 0x000004. Required: `berr_n`=0, `dtack_n` stays 1; release after the strobes negate.
- **Timeout.** Stimulus: TIMEOUT=16, no ack. Required: `berr_n`=0 exactly 16 cycles into WAIT, no second `cpu_req`; a late ack 5 cycles later has no effect.
- **Interrupt acknowledge.** Stimulus: `fc`=7 with the strobes asserted. Required: `vpa_n`=0, `cpu_req` never pulses; release on strobe negation.
- **TAS and reset.**
  - TAS: AS held low, strobes high→low between halves; required: exactly two `cpu_req` pulses, read then write.
  - Reset: `rst` pulsed in WAIT; required: all outputs return to their reset values and the following ack is ignored.
